// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default line parameters and bit-period rounding.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD   = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  // Nearest-integer clocks per bit, so the sampling error stays within half a clock.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; 2-cycle latency, no flow control.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling; strobe appears 2+HALF+9*CLKS_PER_BIT+1 cycles after the start edge.
// No backpressure: each byte or framing error is a single-cycle pulse that the consumer must catch.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned BAUD   = DEFAULT_BAUD
) (
  input  logic       FPGA_CLK,
  input  logic       RESET,
  input  logic       UART_RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int          CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8) begin : g_rate_check
    $error("uart_rx: CLK_HZ/BAUD gives fewer than 8 clocks per bit");
  end

  logic rxs;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (FPGA_CLK),
    .rst (RESET),
    .d   (UART_RXD),
    .q   (rxs)
  );

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             ferr_q,    ferr_d;
  logic             busy_q,    busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        // Still low at half a bit: a real start bit, not a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Return to IDLE mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge FPGA_CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven on UART_RXD, strobes matched against a queue of expected results.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115_200;
  localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF   = CPB / 2;
  // Strobe cycle relative to t0: 2 sync + 1 IDLE->START + (HALF-1) + 9 bit periods + 1 register.
  localparam int LAT    = 3 + HALF + 9 * CPB;
  localparam int P_FAST = int'(real'(CLK_HZ) / (real'(BAUD) * 1.02) + 0.5);
  localparam int P_SLOW = int'(real'(CLK_HZ) / (real'(BAUD) * 0.98) + 0.5);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .FPGA_CLK     (clk),
    .RESET        (rst),
    .UART_RXD     (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         when;
    bit         busy;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] last_good = 8'h00;
  int         total = 0;
  int         bad = 0;
  bit         prev_strobe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rx_valid || rx_frame_err) begin
      chk("single_strobe_kind", 32'(rx_valid & rx_frame_err), 32'd0);
      chk("strobe_not_repeated", 32'(prev_strobe), 32'd0);
      chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("strobe_is_err", 32'(rx_frame_err), 32'(mon_e.is_err));
        chk("rx_data", 32'(rx_data), 32'(mon_e.data));
        chk("busy_at_strobe", 32'(rx_busy), 32'(mon_e.busy));
        if (mon_e.when >= 0) chk("strobe_cycle", cyc + 1, mon_e.when);
      end
    end
    prev_strobe = rx_valid | rx_frame_err;
  end

  // Each call starts #1 after a rising edge and ends #1 after a rising edge.
  task automatic tx_bit(input logic v, input int period);
    rxd = v;
    repeat (period) @(posedge clk);
    #1;
  endtask

  task automatic frame_ok(input logic [7:0] b, input int period, input bit timed);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    e.when   = timed ? cyc + 1 + LAT : -1;
    e.busy   = 1'b0;
    sb.push_back(e);
    last_good = b;
    tx_bit(1'b0, period);
    for (int i = 0; i < 8; i++) tx_bit(b[i], period);
    tx_bit(1'b1, period);
  endtask

  // Stop bit low, then the line stays low for three more bit times before recovering.
  task automatic frame_bad_stop(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    e.when   = cyc + 1 + LAT;
    e.busy   = 1'b1;
    sb.push_back(e);
    tx_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) tx_bit(b[i], CPB);
    tx_bit(1'b0, CPB);
    tx_bit(1'b0, 3 * CPB);
    tx_bit(1'b1, CPB);
  endtask

  initial begin
    #2_500_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 125000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [7:0] b;
    logic [7:0] seq [4];
    seq[0] = 8'h55; seq[1] = 8'hAA; seq[2] = 8'h00; seq[3] = 8'hFF;

    repeat (4) @(posedge clk);
    #1;
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_frame_err", 32'(rx_frame_err), 32'd0);
    chk("reset_rx_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    tx_bit(1'b1, 20);

    frame_ok(8'h2B, CPB, 1'b1);
    tx_bit(1'b1, 50);

    for (int i = 0; i < 4; i++) frame_ok(seq[i], CPB, 1'b1);
    tx_bit(1'b1, 50);

    frame_bad_stop(8'h41);
    frame_ok(8'h42, CPB, 1'b1);
    tx_bit(1'b1, 50);

    // Short low glitch on an idle line.
    t0 = cyc + 1;
    tx_bit(1'b0, 100);
    rxd = 1'b1;
    do @(negedge clk); while (cyc + 1 < t0 + HALF + 2);
    chk("glitch_busy_before_check", 32'(rx_busy), 32'd1);
    @(negedge clk);
    chk("glitch_busy_released", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1;
    tx_bit(1'b1, 50);

    frame_ok(8'hA5, P_FAST, 1'b0);
    tx_bit(1'b1, 50);
    frame_ok(8'hA5, P_SLOW, 1'b0);
    tx_bit(1'b1, 50);

    for (int i = 0; i < 4; i++) begin
      int gap;
      b = 8'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 60));
      if (gap > 0) tx_bit(1'b1, gap);
      frame_ok(b, CPB, 1'b1);
    end
    tx_bit(1'b1, 50);

    // Reset during data bit 4; the sender then abandons the frame and idles.
    b = 8'h3C;
    tx_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) tx_bit(b[i], CPB);
    tx_bit(b[4], CPB / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_good = 8'h00;
    chk("midframe_reset_busy", 32'(rx_busy), 32'd0);
    chk("midframe_reset_valid", 32'(rx_valid), 32'd0);
    tx_bit(1'b1, 2 * CPB);
    chk("midframe_reset_rx_data", 32'(rx_data), 32'h00);
    chk("midframe_reset_idle", 32'(rx_busy), 32'd0);
    frame_ok(8'h3C, CPB, 1'b1);

    for (int i = 0; i < 6000 && sb.size() != 0; i++) @(negedge clk);
    chk("all_strobes_seen", sb.size(), 32'd0);
    chk("final_busy", 32'(rx_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver for the board's RS-232 input pin (UART_RXD, 115200 baud from the USB-serial bridge). It oversamples the line with the 50 MHz system clock and detects start bits. Each byte is sampled at mid-bit, then presented as a byte plus a one-cycle valid strobe. It sits beside the key debouncers in the board top, so a PC can drive the same one-cycle command flags that the buttons produce (e.g. 0x2B '+' increments the counter, 0x2D '-' decrements it).

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- CLKS_PER_BIT (localparam), (CLK_HZ + BAUD/2) / BAUD = 434, clock cycles per bit; must be ≥ 8, otherwise an elaboration error is raised
- HALF (localparam), CLKS_PER_BIT / 2 = 217

Ports:
- FPGA_CLK  in  1  system clock, rising edge
- RESET  in  1  reset, synchronous, active-high (the top drives it from ~RESET_BUT)
- UART_RXD  in  1  asynchronous serial line, idle high
- rx_data  out  8  last correctly framed byte; holds its value until the next good frame
- rx_valid  out  1  one-cycle pulse; rx_data is new in this same cycle
- rx_frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- rx_busy  out  1  high in every state other than IDLE

## Operation
- Input passes a 2-flop synchronizer. Both flops reset to 1. All FSM decisions use the second flop's output (rxs).
- Bit counter: $clog2(CLKS_PER_BIT) bits. It is cleared on every state change and at every sample point.
- Data shift register: 8 bits, LSB received first (shift in at the MSB, shift right).
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rxs = 0, go to START.
  - START: when the counter reaches HALF-1, sample rxs. If it is 1 (a glitch), return to IDLE with no output. If it is 0, go to DATA with the bit index at 0.
  - DATA: when the counter reaches CLKS_PER_BIT-1, sample rxs into the shift register. The bit index is 3 bits; after index 7 is sampled, go to STOP.
  - STOP: when the counter reaches CLKS_PER_BIT-1, sample rxs.
    - If 1: load rx_data from the shift register, pulse rx_valid, and go straight to IDLE. This happens mid-stop-bit, so a back-to-back start edge is caught.
    - If 0: pulse rx_frame_err, leave rx_data unchanged, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs = 1, then go to IDLE. A break condition therefore produces exactly one error pulse.
- Reset values: rx_data = 0x00, rx_valid = 0, rx_frame_err = 0, rx_busy = 0, state = IDLE, counters = 0.
- Reset asserted mid-frame: the partial byte is discarded, no strobe is issued, and the next cycle is IDLE. If the line is low when reset releases, the receiver enters START and the glitch check applies.
- rx_valid and rx_frame_err are never high in the same cycle. They are never high for two consecutive cycles.

## Timing
- t0 = the first rising edge at which UART_RXD is low.
- Start-bit sample: at t0 + 2 + HALF (sync 2 cycles, IDLE→START 1 cycle, HALF-1 counts).
- Data bit k (k = 0..7) is sampled at the start sample + (k+1)·CLKS_PER_BIT.
- Stop bit is sampled at the start sample + 9·CLKS_PER_BIT.
- rx_valid or rx_frame_err is high in the cycle after the stop sample. With defaults, that is t0 + 3 + 217 + 3906 = t0 + 4126.
- Rate tolerance: sampling lands at mid-bit ± (HALF rounding + clock rounding). This allows ±2 % transmitter baud error with the defaults.
- Throughput: one byte per 10 bit times, back-to-back, with no gap needed.

## Structure
- Shared package uart_pkg: the FSM state encoding (localparams), the default CLK_HZ/BAUD, and a function that returns CLKS_PER_BIT for rounding. The future uart_tx uses the same package.
- One sub-module: sync_2ff (parameter RESET_VAL = 1), reused for the key inputs later.
- The FSM, counter and shift register stay in uart_rx. Target size is about 150 lines.

## Test plan
- Byte 0x2B at exactly 115200 baud → rx_valid pulse at t0+4126, rx_data = 0x2B, rx_frame_err stays 0, rx_busy falls the same cycle.
- Bytes 0x55, 0xAA, 0x00, 0xFF sent back-to-back with no idle gap → four rx_valid pulses exactly 4340 cycles apart, each carrying the correct data.
- 0x41 with the stop bit forced low, the line held low 3 more bit times, then 0x42 → one rx_frame_err pulse, rx_data stays at its previous value, then rx_valid with 0x42.
- 100-cycle low glitch on an idle line → no rx_valid or rx_frame_err, and rx_busy returns to 0 within HALF+3 cycles.
- 0xA5 sent at BAUD+2 % and BAUD−2 % → rx_data = 0xA5 in both cases, with no error.
- RESET pulsed for one cycle during data bit 4 of 0x3C → no strobe for that frame, rx_data = 0x00, and a following 0x3C is received correctly.
